// File: rtl/regbank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_arbiter
//  Purpose  : Shares one config/status register bank between the SPI (port 0)
//             and I2C (port 1) peripherals. One buffered request per port,
//             round-robin serialisation, registered bank drive, one-cycle
//             acknowledge with read data, saturating tie counter for debug.
//  Revision : 1.0 - initial release
// ============================================================================
module regbank_arbiter #(
    parameter int ADDR_W = 4,
    parameter int REG_W  = 8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [REG_W-1:0]  p0_wdata,
    output logic              p0_ack,
    output logic [REG_W-1:0]  p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [REG_W-1:0]  p1_wdata,
    output logic              p1_ack,
    output logic [REG_W-1:0]  p1_rdata,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [REG_W-1:0]  bank_wdata,
    output logic              bank_we,
    input  logic [REG_W-1:0]  bank_rdata,
    output logic              busy,
    output logic [7:0]        conflict_cnt
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Per-port request view, indexed by port number
    logic [1:0]        req_w;
    logic [1:0]        we_w;
    logic [ADDR_W-1:0] addr_w  [2];
    logic [REG_W-1:0]  wdata_w [2];

    assign req_w      = {p1_req, p0_req};
    assign we_w       = {p1_we, p0_we};
    assign addr_w[0]  = p0_addr;
    assign addr_w[1]  = p1_addr;
    assign wdata_w[0] = p0_wdata;
    assign wdata_w[1] = p1_wdata;

    // Pending slots
    logic [1:0]        slot_v_q;
    logic [1:0]        slot_we_q;
    logic [ADDR_W-1:0] slot_addr_q  [2];
    logic [REG_W-1:0]  slot_wdata_q [2];

    // Arbitration state
    logic              win_q, win_d;
    logic              last_grant_q;
    logic              start_w;
    logic              tie_w;
    logic [7:0]        conflict_cnt_q;

    // Registered outputs
    logic [ADDR_W-1:0] bank_addr_q;
    logic [REG_W-1:0]  bank_wdata_q;
    logic              bank_we_q;
    logic [1:0]        ack_q;
    logic [REG_W-1:0]  rdata_q [2];

    // FSM state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and winner selection; a tie goes to the port not granted last
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        start_w = 1'b0;
        tie_w   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ena && (|slot_v_q)) begin
                    state_d = S_ACCESS;
                    start_w = 1'b1;
                    tie_w   = &slot_v_q;
                    win_d   = tie_w ? ~last_grant_q : slot_v_q[1];
                end
            end
            S_ACCESS: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Slot capture and release; the winner's slot frees on the ACCESS->IDLE edge,
    // so a request issued in the ack cycle is already accepted
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            slot_v_q  <= '0;
            slot_we_q <= '0;
            for (int i = 0; i < 2; i++) begin
                slot_addr_q[i]  <= '0;
                slot_wdata_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (state_q == S_ACCESS && win_q == 1'(i)) begin
                    slot_v_q[i] <= 1'b0;
                end else if (ena && req_w[i] && !slot_v_q[i]) begin
                    slot_v_q[i]     <= 1'b1;
                    slot_we_q[i]    <= we_w[i];
                    slot_addr_q[i]  <= addr_w[i];
                    slot_wdata_q[i] <= wdata_w[i];
                end
            end
        end
    end

    // Grant bookkeeping, bank drive and the saturating tie counter
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            win_q          <= 1'b0;
            last_grant_q   <= 1'b1;
            conflict_cnt_q <= '0;
            bank_addr_q    <= '0;
            bank_wdata_q   <= '0;
            bank_we_q      <= 1'b0;
        end else begin
            if (start_w) begin
                win_q        <= win_d;
                last_grant_q <= win_d;
                bank_addr_q  <= slot_addr_q[win_d];
                bank_wdata_q <= slot_wdata_q[win_d];
                bank_we_q    <= slot_we_q[win_d];
                if (tie_w && conflict_cnt_q != 8'hFF) begin
                    conflict_cnt_q <= conflict_cnt_q + 8'd1;
                end
            end else begin
                bank_addr_q  <= '0;
                bank_wdata_q <= '0;
                bank_we_q    <= 1'b0;
            end
        end
    end

    // Completion: one-cycle ack and read-data capture for the served port
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ack_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            ack_q <= '0;
            if (state_q == S_ACCESS) begin
                ack_q[win_q]   <= 1'b1;
                rdata_q[win_q] <= bank_rdata;
            end
        end
    end

    assign p0_ack       = ack_q[0];
    assign p1_ack       = ack_q[1];
    assign p0_rdata     = rdata_q[0];
    assign p1_rdata     = rdata_q[1];
    assign bank_addr    = bank_addr_q;
    assign bank_wdata   = bank_wdata_q;
    assign bank_we      = bank_we_q;
    assign busy         = (state_q == S_ACCESS);
    assign conflict_cnt = conflict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regbank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regbank_arbiter
//  Purpose  : Directed self-checking bench for regbank_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_arbiter;

    logic       clk = 1'b0;
    logic       rstb;
    logic       ena;
    logic       p0_req, p0_we, p1_req, p1_we;
    logic [3:0] p0_addr, p1_addr;
    logic [7:0] p0_wdata, p1_wdata;
    logic       p0_ack, p1_ack;
    logic [7:0] p0_rdata, p1_rdata;
    logic [3:0] bank_addr;
    logic [7:0] bank_wdata;
    logic       bank_we;
    logic [7:0] bank_rdata;
    logic       busy;
    logic [7:0] conflict_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regbank_arbiter #(.ADDR_W(4), .REG_W(8)) dut (
        .clk(clk), .rstb(rstb), .ena(ena),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_we(bank_we),
        .bank_rdata(bank_rdata), .busy(busy), .conflict_cnt(conflict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the n-th next rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstb   = 1'b0;
        p0_req = 1'b0; p1_req = 1'b0;
        tick(2);
        rstb = 1'b1;
    endtask

    int p1_ack_cyc;
    int p0_acks_before;
    int busy_seen;
    int p1_acks_seen;

    initial begin
        rstb = 1'b0; ena = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        bank_rdata = 8'h00;

        // Reset state
        apply_reset();
        chk("rst_bank_we",   32'(bank_we), 32'h0);
        chk("rst_bank_addr", 32'(bank_addr), 32'h0);
        chk("rst_busy",      32'(busy), 32'h0);
        chk("rst_acks",      32'({p1_ack, p0_ack}), 32'h0);
        chk("rst_rdata",     32'({p1_rdata, p0_rdata}), 32'h0);
        chk("rst_conflict",  32'(conflict_cnt), 32'h0);

        // Port 0 read of addr 9, bank returns A5
        bank_rdata = 8'hA5;
        p0_we = 1'b0; p0_addr = 4'h9; p0_req = 1'b1;     // cycle 0
        tick(1); p0_req = 1'b0;                           // cycle 1
        chk("rd_c1_busy", 32'(busy), 32'h0);
        tick(1);                                          // cycle 2
        chk("rd_c2_addr", 32'(bank_addr), 32'h9);
        chk("rd_c2_we",   32'(bank_we), 32'h0);
        chk("rd_c2_busy", 32'(busy), 32'h1);
        chk("rd_c2_ack",  32'(p0_ack), 32'h0);
        tick(1);                                          // cycle 3
        chk("rd_c3_ack",   32'(p0_ack), 32'h1);
        chk("rd_c3_rdata", 32'(p0_rdata), 32'hA5);
        chk("rd_c3_addr",  32'(bank_addr), 32'h0);
        bank_rdata = 8'h00;
        tick(1);                                          // cycle 4
        chk("rd_c4_ack",  32'(p0_ack), 32'h0);
        chk("rd_c4_hold", 32'(p0_rdata), 32'hA5);

        // Port 1 write of 3C to addr 2, bank returns 5A
        bank_rdata = 8'h5A;
        p1_we = 1'b1; p1_addr = 4'h2; p1_wdata = 8'h3C; p1_req = 1'b1;
        tick(1); p1_req = 1'b0;
        tick(1);                                          // cycle 2
        chk("wr_c2_we",    32'(bank_we), 32'h1);
        chk("wr_c2_addr",  32'(bank_addr), 32'h2);
        chk("wr_c2_wdata", 32'(bank_wdata), 32'h3C);
        tick(1);                                          // cycle 3
        chk("wr_c3_we",    32'(bank_we), 32'h0);
        chk("wr_c3_ack",   32'({p1_ack, p0_ack}), 32'h2);
        chk("wr_c3_rdata", 32'(p1_rdata), 32'h5A);
        chk("wr_p0_hold",  32'(p0_rdata), 32'hA5);

        // Simultaneous requests after reset: port 0 first, then port 1
        apply_reset();
        bank_rdata = 8'h77;
        p0_we = 1'b0; p0_addr = 4'h1; p1_we = 1'b0; p1_addr = 4'h7;
        p0_req = 1'b1; p1_req = 1'b1;
        tick(1); p0_req = 1'b0; p1_req = 1'b0;
        tick(1);                                          // cycle 2
        chk("tie_c2_addr", 32'(bank_addr), 32'h1);
        tick(1);                                          // cycle 3
        chk("tie_c3_ack",  32'({p1_ack, p0_ack}), 32'h1);
        tick(1);                                          // cycle 4
        chk("tie_c4_addr", 32'(bank_addr), 32'h7);
        chk("tie_c4_busy", 32'(busy), 32'h1);
        tick(1);                                          // cycle 5
        chk("tie_c5_ack",  32'({p1_ack, p0_ack}), 32'h2);
        chk("tie_cnt",     32'(conflict_cnt), 32'h1);

        // Starvation: port 0 re-requests on every ack, port 1 requests once
        apply_reset();
        p1_ack_cyc = -1; p0_acks_before = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (p1_ack && p1_ack_cyc < 0) p1_ack_cyc = cyc;
            if (p0_ack && p1_ack_cyc < 0) p0_acks_before++;
            p0_req = (cyc == 0) || p0_ack;
            p1_req = (cyc == 3);
            tick(1);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        chk("starve_p1_ack_cyc", 32'(p1_ack_cyc), 32'd6);
        chk("starve_p0_before",  32'(p0_acks_before), 32'd1);

        // Counter saturation over 300 ties
        apply_reset();
        for (int t = 0; t < 300; t++) begin
            p0_req = 1'b1; p1_req = 1'b1;
            tick(1);
            p0_req = 1'b0; p1_req = 1'b0;
            tick(5);
            if (t == 253) chk("sat_cnt_254", 32'(conflict_cnt), 32'd254);
            if (t == 254) chk("sat_cnt_255", 32'(conflict_cnt), 32'd255);
        end
        chk("sat_cnt_300", 32'(conflict_cnt), 32'd255);

        // Reset pulsed during a write ACCESS
        apply_reset();
        p1_we = 1'b1; p1_addr = 4'hB; p1_wdata = 8'hE1; p1_req = 1'b1;
        tick(1); p1_req = 1'b0;
        tick(1);                                          // cycle 2
        chk("rstw_c2_we", 32'(bank_we), 32'h1);
        rstb = 1'b0;
        #1;
        chk("rstw_we_drop", 32'(bank_we), 32'h0);
        chk("rstw_outs",    32'({busy, bank_addr, bank_wdata}), 32'h0);
        tick(1);                                          // cycle 3
        chk("rstw_no_ack",  32'({p1_ack, p0_ack}), 32'h0);
        rstb = 1'b1;
        tick(1);
        bank_rdata = 8'h3D;
        p0_we = 1'b0; p0_addr = 4'h4; p0_req = 1'b1;
        tick(1); p0_req = 1'b0;
        tick(2);
        chk("rstw_after_ack",   32'(p0_ack), 32'h1);
        chk("rstw_after_rdata", 32'(p0_rdata), 32'h3D);
        chk("rstw_p1_silent",   32'(p1_ack), 32'h0);

        // Disabled block keeps its pending slot and starts nothing
        apply_reset();
        bank_rdata = 8'hC4;
        p0_we = 1'b0; p0_addr = 4'h6; p0_req = 1'b1;     // cycle 0, accepted
        tick(1); p0_req = 1'b0; ena = 1'b0;               // cycle 1
        busy_seen = 0; p1_acks_seen = 0;
        for (int cyc = 1; cyc < 6; cyc++) begin
            if (busy || p0_ack) busy_seen++;
            p1_req = (cyc == 2);                          // dropped while disabled
            tick(1);
        end
        p1_req = 1'b0;
        chk("ena_no_access", 32'(busy_seen), 32'd0);
        ena = 1'b1;                                       // cycle 6: arbitration
        tick(1);                                          // cycle 7
        chk("ena_access_addr", 32'(bank_addr), 32'h6);
        chk("ena_access_busy", 32'(busy), 32'h1);
        tick(1);                                          // cycle 8
        chk("ena_ack",   32'(p0_ack), 32'h1);
        chk("ena_rdata", 32'(p0_rdata), 32'hC4);
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (p1_ack) p1_acks_seen++;
            tick(1);
        end
        chk("ena_p1_dropped", 32'(p1_acks_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regbank_arbiter.md
# regbank_arbiter

Two-port arbiter that shares the single config/status register bank between the SPI peripheral (port 0) and the I2C peripheral (port 1). Each peripheral issues single-cycle access requests in the `clk` domain. The arbiter buffers one request per port and serialises them onto the bank with round-robin priority. It returns read data with a one-cycle acknowledge and counts arbitration conflicts for debug.

## Interface
Parameters:
- `ADDR_W`, default 4: register bank address width.
- `REG_W`, default 8: register data width.

Ports:
- `clk` input 1: system clock.
- `rstb` input 1: reset, asynchronous, active-low.
- `ena` input 1: block enable.
- `p0_req` input 1: port 0 (SPI) access request pulse.
- `p0_we` input 1: port 0 write (1) / read (0).
- `p0_addr` input ADDR_W: port 0 register address.
- `p0_wdata` input REG_W: port 0 write data.
- `p0_ack` output 1: port 0 access-complete pulse.
- `p0_rdata` output REG_W: port 0 read data; valid when `p0_ack`=1.
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_ack`, `p1_rdata`: same as port 0, for port 1 (I2C).
- `bank_addr` output ADDR_W: address to the register bank.
- `bank_wdata` output REG_W: write data to the register bank.
- `bank_we` output 1: bank write strobe, one cycle.
- `bank_rdata` input REG_W: combinational read data from the bank.
- `busy` output 1: high while the FSM is in ACCESS.
- `conflict_cnt` output 8: saturating count of tied arbitrations.

## Operation
Pending slots:
- Each port has one slot holding `valid`, `we`, `addr` and `wdata`.
- `pN_req` is sampled on the rising edge. It is accepted when `ena`=1 and the slot is empty. The slot counts as empty in the cycle where `pN_ack`=1.
- A request that arrives while the slot is full is silently dropped. This is a protocol violation: a requester must wait for `ack` before issuing its next request.

FSM states:
- IDLE to ACCESS: when `ena`=1 and at least one slot is valid.
  - Winner when only one slot is valid: that port.
  - Winner when both slots are valid: the port not equal to `last_grant`.
  - `last_grant` is updated to the winner.
  - `conflict_cnt` increments on a tie and saturates at 255.
- ACCESS to IDLE: unconditionally after one cycle.
  - The winner's slot is cleared.
  - `pN_rdata` is loaded from `bank_rdata`, for writes as well.
  - `pN_ack` pulses for one cycle.

Bank drive:
- All bank outputs are registered.
- During ACCESS: `bank_addr` and `bank_wdata` come from the winner's slot, and `bank_we` = winner's `we`.
- Outside ACCESS: `bank_we`=0, `bank_addr`=0, `bank_wdata`=0.

Enable:
- When `ena`=0, no new requests are captured and no new arbitration starts.
- An access already in ACCESS completes and acks normally.
- Pending slots are retained.

Reset:
- Values: all outputs 0, both slots empty, state IDLE, `last_grant`=1 (so port 0 wins the first tie).
- Reset asserted during ACCESS drops `bank_we` immediately. No ack is issued and the slots are lost.

## Timing
Single request, cycle by cycle:
- Req in cycle N: the slot is valid from edge N+1.
- Cycle N+1: arbitration (IDLE).
- Cycle N+2: ACCESS; bank signals are driven and the bank write occurs at edge N+3.
- Cycle N+3: `pN_ack`=1 with `pN_rdata`, and the state is back in IDLE.
- Latency from req to ack is 3 cycles.

Throughput:
- Maximum is one bank access per 2 cycles.
- For a tie at cycle N+1: the loser's ACCESS is cycle N+4 and its ack is in cycle N+5.

Re-request:
- A requester that re-requests in its own ack cycle is accepted. Its next ack comes 3 cycles later unless it loses arbitration.

Data-hold rules:
- `pN_rdata` holds its value until that port's next ack.
- `conflict_cnt` only resets via `rstb`.

## Test plan
- Port 0 read, addr 4'h9 with `bank_rdata`=8'hA5. Req in cycle 0 -> `bank_addr`=9 with `bank_we`=0 in cycle 2, then `p0_ack`=1 with `p0_rdata`=8'hA5 in cycle 3.
- Port 1 write, addr 4'h2 with wdata 8'h3C -> `bank_we`=1 for exactly one cycle with `bank_addr`=2 and `bank_wdata`=8'h3C, and `p1_ack` in the following cycle.
- Both ports request in the same cycle after reset -> port 0 is served first (ack cycle 3), then port 1 (ack cycle 5), and `conflict_cnt`=1.
- Port 0 re-requests on every ack while port 1 requests once -> port 1 is acked within 2 bank accesses, proving no starvation.
- Tie forced 300 times -> `conflict_cnt` saturates at 255.
- Two separate fault cases:
  - `rstb` pulsed low during ACCESS of a write -> `bank_we` drops immediately, no ack, all outputs 0, and a new request after release completes normally.
  - `ena`=0 with a pending slot -> no ACCESS occurs until `ena` returns to 1.
